// File: rtl/cic_pkg.sv
// Shared CIC helpers: integer log2, stage width functions and the default integrator width.
package cic_pkg;

    function automatic int clog2_l(input longint v);
        for (int i = 0; i < 63; i++) begin
            if ((longint'(1) << i) >= v) return i;
        end
        return 63;
    endfunction

    function automatic longint ipow(input longint b, input int e);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic int comb_w(input int inp_dw, input int j);
        return inp_dw + j;
    endfunction

    // Integrator width covers the worst-case interpolator gain (R*M)^N / R.
    function automatic int int_w(input int inp_dw, input int r, input int n, input int m);
        return inp_dw + clog2_l(ipow(longint'(r * m), n) / longint'(r));
    endfunction

    localparam int W = int_w(16, 8, 5, 1);

endpackage

// File: rtl/cic_i_ctrl.sv
// Slot controller for cic_i: IDLE/RUN FSM, phase counter, rate registers, slot strobes.
// CIC_I_VARIABLE_RATE_EN enables the run-time rate port; otherwise the rate is fixed at CIC_R.
module cic_i_ctrl import cic_pkg::*; #(
    parameter int RATE_DW = 16,
    parameter int CIC_R   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [RATE_DW-1:0] rate_data,
    input  logic               rate_valid,
    output logic               ready,
    output logic               underflow,
    output logic               slot,
    output logic               run
);

    localparam logic [0:0]         IDLE  = 1'b0;
    localparam logic [0:0]         RUN   = 1'b1;
    localparam logic [RATE_DW-1:0] ONE   = RATE_DW'(1);
    localparam logic [RATE_DW-1:0] R_MAX = RATE_DW'(CIC_R);

    logic [0:0]         state;
    logic [RATE_DW-1:0] phase;
    logic [RATE_DW-1:0] rate;
    logic               wrap;

    assign run       = (state == RUN);
    assign wrap      = run && (phase == rate - ONE);
    assign ready     = !run || (phase == '0);
    assign slot      = run ? (phase == '0) : in_valid;
    assign underflow = run && (phase == '0) && !in_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            phase <= '0;
        end else if (!run) begin
            if (in_valid) begin
                state <= RUN;
                phase <= (rate == ONE) ? '0 : ONE;
            end
        end else begin
            phase <= wrap ? '0 : phase + ONE;
        end
    end

`ifdef CIC_I_VARIABLE_RATE_EN
    logic [RATE_DW-1:0] pend;
    logic               pend_vld;
    logic               wr_ok;

    assign wr_ok = rate_valid && (rate_data >= ONE) && (rate_data <= R_MAX);

    // New rates only take effect at a frame boundary; a write on the wrap cycle itself wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate     <= R_MAX;
            pend     <= '0;
            pend_vld <= 1'b0;
        end else if (wrap) begin
            if (wr_ok)         rate <= rate_data;
            else if (pend_vld) rate <= pend;
            pend_vld <= 1'b0;
        end else if (wr_ok) begin
            pend     <= rate_data;
            pend_vld <= 1'b1;
        end
    end
`else
    logic unused_rate;

    assign rate        = R_MAX;
    assign unused_rate = ^{rate_data, rate_valid};
`endif

endmodule

// File: rtl/cic_i.sv
// CIC interpolator: N combs at slot rate, zero-stuffing upsampler, N integrators at clk rate.
// CIC_I_VARIABLE_RATE_EN enables the run-time interpolation ratio port.
module cic_i import cic_pkg::*; #(
    parameter int INP_DW  = 16,
    parameter int OUT_DW  = 16,
    parameter int RATE_DW = 16,
    parameter int CIC_R   = 8,
    parameter int CIC_N   = 5,
    parameter int CIC_M   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [INP_DW-1:0] s_axis_in_tdata,
    input  logic                     s_axis_in_tvalid,
    output logic                     s_axis_in_tready,
    input  logic        [RATE_DW-1:0] s_axis_rate_tdata,
    input  logic                     s_axis_rate_tvalid,
    output logic signed [OUT_DW-1:0] m_axis_out_tdata,
    output logic                     m_axis_out_tvalid,
    output logic                     underflow
);

    localparam int IW = int_w(INP_DW, CIC_R, CIC_N, CIC_M);
    localparam int CW = comb_w(INP_DW, CIC_N);

    logic                     run;
    logic                     slot;
    logic signed [INP_DW-1:0] sample;
    logic                     stb_p  [0:CIC_N];
    logic signed [CW-1:0]     comb_p [0:CIC_N];
    logic signed [IW-1:0]     int_p  [0:CIC_N];
    logic [2*CIC_N-1:0]       vld_p;
    logic signed [OUT_DW-1:0] out_p;

    cic_i_ctrl #(
        .RATE_DW (RATE_DW),
        .CIC_R   (CIC_R)
    ) u_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (s_axis_in_tvalid),
        .rate_data  (s_axis_rate_tdata),
        .rate_valid (s_axis_rate_tvalid),
        .ready      (s_axis_in_tready),
        .underflow  (underflow),
        .slot       (slot),
        .run        (run)
    );

    always_comb begin
        sample = '0;
        if (s_axis_in_tvalid) sample = s_axis_in_tdata;
    end

    assign stb_p[0]  = slot;
    assign comb_p[0] = CW'(sample);

    // Comb stages: stage j holds INP_DW+j bits and advances only on its strobe.
    for (genvar j = 1; j <= CIC_N; j++) begin : g_comb
        localparam int SW = comb_w(INP_DW, j);

        logic signed [SW-2:0] dly_p [CIC_M];
        logic signed [SW-1:0] acc_p;
        logic                 stb_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc_p <= '0;
                stb_q <= 1'b0;
                for (int k = 0; k < CIC_M; k++) dly_p[k] <= '0;
            end else begin
                stb_q <= stb_p[j-1];
                if (stb_p[j-1]) begin
                    acc_p    <= SW'(comb_p[j-1] - CW'(dly_p[CIC_M-1]));
                    dly_p[0] <= (SW-1)'(comb_p[j-1]);
                    for (int k = 1; k < CIC_M; k++) dly_p[k] <= dly_p[k-1];
                end
            end
        end

        assign comb_p[j] = CW'(acc_p);
        assign stb_p[j]  = stb_q;
    end

    // Upsampler: the comb result is injected once per slot, zeros fill the rest.
    assign int_p[0] = stb_p[CIC_N] ? IW'(comb_p[CIC_N]) : '0;

    for (genvar k = 1; k <= CIC_N; k++) begin : g_int
        logic signed [IW-1:0] acc_p;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)  acc_p <= '0;
            else if (run)  acc_p <= acc_p + int_p[k-1];
        end

        assign int_p[k] = acc_p;
    end

    // Output register; valid follows the first accept through the 2N-deep pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_p <= '0;
            vld_p <= '0;
        end else begin
            out_p <= int_p[CIC_N][IW-1 -: OUT_DW];
            vld_p <= {vld_p[2*CIC_N-2:0], run};
        end
    end

    assign m_axis_out_tdata  = out_p;
    assign m_axis_out_tvalid = vld_p[2*CIC_N-1];

endmodule
